dmem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the single-ported data memory.
- Port 0 is the CPU load/store unit. Port 1 is a secondary master: program loader, debug or DMA.
- Grants at most one request per cycle, drives the memory's addr/din/memOp/we, routes the one-cycle-latency read data back to the winner and raises an error response for illegal accesses.
- Fixed priority to port 0, with a starvation counter that forces a port-1 grant.

---
 rtl/dmem_pkg.sv | 49 ++++
 rtl/dmem_access_check.sv | 22 ++
 rtl/dmem_arbiter.sv | 124 ++++++++++++
 tb/tb_dmem_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared memory-op encodings, request/response types and legality
//            helper for the data-memory arbiter and its access checker.
// Revision : 1.0
// ============================================================================
package dmem_pkg;

    localparam int unsigned PKG_ADDR_W = 32;
    localparam int unsigned PKG_DATA_W = 32;

    typedef enum logic [2:0] {
        MEM_B  = 3'd0,
        MEM_H  = 3'd1,
        MEM_W  = 3'd2,
        MEM_BU = 3'd4,
        MEM_HU = 3'd5
    } memop_e;

    typedef struct packed {
        logic [PKG_ADDR_W-1:0] addr;
        logic [PKG_DATA_W-1:0] wdata;
        logic [2:0]            memop;
        logic                  we;
    } mem_req_t;

    typedef struct packed {
        logic [PKG_DATA_W-1:0] rdata;
        logic                  err;
    } mem_rsp_t;

    // Encoding and alignment only; the address range depends on the memory size.
    function automatic logic memop_legal(input logic [2:0] memop, input logic we,
                                         input logic [1:0] addr_lo);
        logic ok;
        case (memop)
            MEM_B:   ok = 1'b1;
            MEM_BU:  ok = !we;
            MEM_H:   ok = !addr_lo[0];
            MEM_HU:  ok = !we && !addr_lo[0];
            MEM_W:   ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_access_check.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_check
// Purpose  : Combinational legality check of one memory request.
// Revision : 1.0
// ============================================================================
module dmem_access_check import dmem_pkg::*; #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 32768
) (
    input  logic [2:0]        memop_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              err_o
);

    localparam logic [63:0] LIMIT = 64'(DEPTH_WORDS) * 64'd4;

    assign err_o = !memop_legal(memop_i, we_i, addr_i[1:0]) || (64'(addr_i) >= LIMIT);

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-port fixed-priority arbiter with starvation guard in front of
//            the single-ported data memory; one-cycle response path.
// Revision : 1.0
// ============================================================================
module dmem_arbiter import dmem_pkg::*; #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 32768,
    parameter int MAX_WAIT    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [2:0]        p0_memop,
    input  logic              p0_we,
    output logic              p0_rsp_valid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_rsp_err,
    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [2:0]        p1_memop,
    input  logic              p1_we,
    output logic              p1_rsp_valid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic [2:0]        mem_memop,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    mem_req_t          req0, req1, win;
    logic [7:0]        wait_q, wait_d;
    logic              gnt0, gnt1, any_gnt, chk_err, req_err, issue, rd_ok;
    logic [ADDR_W-1:0] last_addr_q;
    logic [DATA_W-1:0] last_din_q;
    logic [2:0]        last_op_q;
    logic              rsp_vld_q, rsp_port_q, rsp_is_read_q, rsp_err_q;

    assign req0 = '{addr: p0_addr, wdata: p0_wdata, memop: p0_memop, we: p0_we};
    assign req1 = '{addr: p1_addr, wdata: p1_wdata, memop: p1_memop, we: p1_we};

    // Grants are masked while in reset so no request is accepted or forwarded.
    assign gnt1    = rst_n && p1_valid && ((wait_q == MAX_WAIT_C) || !p0_valid);
    assign gnt0    = rst_n && p0_valid && !gnt1;
    assign any_gnt = gnt0 || gnt1;
    assign win     = gnt1 ? req1 : req0;

    assign p0_ready = gnt0;
    assign p1_ready = gnt1;

    dmem_access_check #(
        .ADDR_W      (ADDR_W),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_check (
        .memop_i (win.memop),
        .we_i    (win.we),
        .addr_i  (win.addr),
        .err_o   (chk_err)
    );

    assign req_err = any_gnt && chk_err;
    assign issue   = any_gnt && !chk_err;

    // Idle and rejected cycles replay the last issued command to avoid toggling.
    assign mem_we    = issue && win.we;
    assign mem_addr  = issue ? win.addr  : last_addr_q;
    assign mem_din   = issue ? win.wdata : last_din_q;
    assign mem_memop = issue ? win.memop : last_op_q;

    always_comb begin
        wait_d = wait_q;
        if (!p1_valid || gnt1) begin
            wait_d = 8'd0;
        end else if (wait_q < MAX_WAIT_C) begin
            wait_d = wait_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q        <= 8'd0;
            rsp_vld_q     <= 1'b0;
            rsp_port_q    <= 1'b0;
            rsp_is_read_q <= 1'b0;
            rsp_err_q     <= 1'b0;
            last_addr_q   <= '0;
            last_din_q    <= '0;
            last_op_q     <= 3'd0;
        end else begin
            wait_q        <= wait_d;
            rsp_vld_q     <= any_gnt;
            rsp_port_q    <= gnt1;
            rsp_is_read_q <= !win.we;
            rsp_err_q     <= req_err;
            if (issue) begin
                last_addr_q <= win.addr;
                last_din_q  <= win.wdata;
                last_op_q   <= win.memop;
            end
        end
    end

    assign rd_ok        = rsp_is_read_q && !rsp_err_q;
    assign p0_rsp_valid = rsp_vld_q && !rsp_port_q;
    assign p1_rsp_valid = rsp_vld_q && rsp_port_q;
    assign p0_rdata     = (p0_rsp_valid && rd_ok) ? mem_dout : '0;
    assign p1_rdata     = (p1_rsp_valid && rd_ok) ? mem_dout : '0;
    assign p0_rsp_err   = p0_rsp_valid && rsp_err_q;
    assign p1_rsp_err   = p1_rsp_valid && rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter with a byte-level memory model.
// Revision : 1.0
// ============================================================================
module tb_dmem_arbiter;

    localparam int DEPTH  = 1024;
    localparam int NBYTES = DEPTH * 4;
    localparam int MAXW   = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p0_valid = 0, p0_we = 0, p1_valid = 0, p1_we = 0;
    logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
    logic [2:0]  p0_memop = 0, p1_memop = 0;
    logic        p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err;
    logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_din;
    logic [31:0] mem_dout = 32'd0;
    logic [2:0]  mem_memop;
    logic        mem_we;

    dmem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(DEPTH), .MAX_WAIT(MAXW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_memop(p0_memop), .p0_we(p0_we), .p0_rsp_valid(p0_rsp_valid),
        .p0_rdata(p0_rdata), .p0_rsp_err(p0_rsp_err),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_memop(p1_memop), .p1_we(p1_we), .p1_rsp_valid(p1_rsp_valid),
        .p1_rdata(p1_rdata), .p1_rsp_err(p1_rsp_err),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_memop(mem_memop), .mem_we(mem_we),
        .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Data memory: write at the clock edge, sized/extended read data one cycle later.
    logic [31:0] dm [DEPTH];
    always @(posedge clk) begin : env_mem
        logic [31:0] w, nw, b, h;
        logic [1:0]  lo;
        w  = dm[mem_addr[11:2]];
        lo = mem_addr[1:0];
        b  = w >> (8 * lo);
        h  = w >> (16 * lo[1]);
        case (mem_memop)
            3'd0:    mem_dout <= {{24{b[7]}}, b[7:0]};
            3'd1:    mem_dout <= {{16{h[15]}}, h[15:0]};
            3'd4:    mem_dout <= {24'd0, b[7:0]};
            3'd5:    mem_dout <= {16'd0, h[15:0]};
            default: mem_dout <= w;
        endcase
        if (mem_we) begin
            nw = w;
            case (mem_memop[1:0])
                2'd0:    nw[8*lo +: 8] = mem_din[7:0];
                2'd1:    nw[16*lo[1] +: 16] = mem_din[15:0];
                default: nw = mem_din;
            endcase
            dm[mem_addr[11:2]] <= nw;
        end
    end

    typedef struct packed {
        logic        v;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  op;
        logic        we;
    } breq_t;

    // Reference model state
    logic [7:0]  mm [NBYTES];
    int          starve = 0;
    bit          pend_vld = 0, pend_port = 0, pend_err = 0;
    logic [31:0] pend_rdata = 0;
    logic [31:0] last_a = 0, last_d = 0;
    logic [2:0]  last_op = 0;
    int          n_cmp = 0, n_bad = 0;

    function automatic breq_t mk(input logic v, input logic [31:0] a, input logic [31:0] d,
                                 input logic [2:0] op, input logic we);
        breq_t r;
        r.v = v; r.a = a; r.d = d; r.op = op; r.we = we;
        return r;
    endfunction

    function automatic int size_of(input logic [2:0] op);
        if (op == 3'd2) return 4;
        if (op == 3'd1 || op == 3'd5) return 2;
        return 1;
    endfunction

    function automatic bit legal(input breq_t r);
        if (r.we && !(r.op inside {3'd0, 3'd1, 3'd2})) return 0;
        if (!r.we && !(r.op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
        if ((r.a % size_of(r.op)) != 0) return 0;
        if (r.a >= NBYTES) return 0;
        return 1;
    endfunction

    function automatic logic [31:0] load_val(input breq_t r);
        logic [7:0]  b;
        logic [15:0] h;
        b = mm[r.a];
        h = (r.op == 3'd0 || r.op == 3'd4) ? 16'd0 : {mm[r.a + 1], mm[r.a]};
        case (r.op)
            3'd0:    return {{24{b[7]}}, b};
            3'd4:    return {24'd0, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd5:    return {16'd0, h};
            default: return {mm[r.a + 3], mm[r.a + 2], mm[r.a + 1], mm[r.a]};
        endcase
    endfunction

    function automatic breq_t rnd();
        breq_t r;
        r.v  = ($urandom_range(0, 3) != 0);
        r.op = 3'($urandom_range(0, 7));
        r.we = 1'($urandom_range(0, 1));
        r.d  = $urandom;
        r.a  = ($urandom_range(0, 7) == 0) ? 32'(NBYTES - 4 + $urandom_range(0, 7))
                                           : 32'($urandom_range(0, 63));
        if ($urandom_range(0, 3) != 0) begin
            if (r.op == 3'd3 || r.op > 3'd5) r.op = 3'd2;
            if (r.we && r.op > 3'd2) r.op = r.op - 3'd4;
            if (r.op != 3'd0 && r.op != 3'd4) r.a[0] = 1'b0;
            if (r.op == 3'd2) r.a[1] = 1'b0;
        end
        return r;
    endfunction

    // One clock cycle, entered and left at the falling edge.
    task automatic step(input breq_t r0, input breq_t r1, output bit g0, output bit g1);
        bit          win1, has, lg;
        breq_t       w;
        logic [31:0] e0d, e1d;
        e0d = (pend_vld && !pend_port) ? pend_rdata : 32'd0;
        e1d = (pend_vld && pend_port) ? pend_rdata : 32'd0;
        n_cmp += 6;
        if (p0_rsp_valid !== (pend_vld && !pend_port)) begin
            n_bad++; $display("FAIL p0_rsp_valid got=%b want=%b", p0_rsp_valid, pend_vld && !pend_port);
        end
        if (p1_rsp_valid !== (pend_vld && pend_port)) begin
            n_bad++; $display("FAIL p1_rsp_valid got=%b want=%b", p1_rsp_valid, pend_vld && pend_port);
        end
        if (p0_rdata !== e0d) begin
            n_bad++; $display("FAIL p0_rdata got=%h want=%h", p0_rdata, e0d);
        end
        if (p1_rdata !== e1d) begin
            n_bad++; $display("FAIL p1_rdata got=%h want=%h", p1_rdata, e1d);
        end
        if (p0_rsp_err !== (pend_vld && !pend_port && pend_err)) begin
            n_bad++; $display("FAIL p0_rsp_err got=%b want=%b", p0_rsp_err, pend_vld && !pend_port && pend_err);
        end
        if (p1_rsp_err !== (pend_vld && pend_port && pend_err)) begin
            n_bad++; $display("FAIL p1_rsp_err got=%b want=%b", p1_rsp_err, pend_vld && pend_port && pend_err);
        end

        p0_valid = r0.v; p0_addr = r0.a; p0_wdata = r0.d; p0_memop = r0.op; p0_we = r0.we;
        p1_valid = r1.v; p1_addr = r1.a; p1_wdata = r1.d; p1_memop = r1.op; p1_we = r1.we;
        #1;
        has  = r0.v || r1.v;
        win1 = r1.v && (starve >= MAXW || !r0.v);
        w    = win1 ? r1 : r0;
        lg   = has && legal(w);
        n_cmp += 3;
        if (p0_ready !== (r0.v && !win1)) begin
            n_bad++; $display("FAIL p0_ready got=%b want=%b", p0_ready, r0.v && !win1);
        end
        if (p1_ready !== win1) begin
            n_bad++; $display("FAIL p1_ready got=%b want=%b", p1_ready, win1);
        end
        if (mem_we !== (lg && w.we)) begin
            n_bad++; $display("FAIL mem_we got=%b want=%b", mem_we, lg && w.we);
        end
        if (lg) begin
            last_a = w.a; last_d = w.d; last_op = w.op;
        end
        n_cmp++;
        if (mem_addr !== last_a || mem_din !== last_d || mem_memop !== last_op) begin
            n_bad++;
            $display("FAIL mem_cmd got=%h/%h/%0d want=%h/%h/%0d",
                     mem_addr, mem_din, mem_memop, last_a, last_d, last_op);
        end

        if (r1.v && !win1) starve = (starve < MAXW) ? starve + 1 : MAXW;
        else starve = 0;
        pend_vld   = has;
        pend_port  = win1;
        pend_err   = has && !lg;
        pend_rdata = (lg && !w.we) ? load_val(w) : 32'd0;
        if (lg && w.we) begin
            for (int i = 0; i < size_of(w.op); i++) mm[w.a + i] = w.d[8*i +: 8];
        end
        g0 = p0_ready;
        g1 = p1_ready;
        @(negedge clk);
    endtask

    function automatic breq_t idle();
        return mk(1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
    endfunction

    task automatic model_reset();
        pend_vld = 0; pend_port = 0; pend_err = 0; pend_rdata = 0;
        starve = 0; last_a = 0; last_d = 0; last_op = 0;
    endtask

    task automatic test_reset();
        p0_valid = 1; p0_memop = 3'd2; p0_we = 1; p0_addr = 32'h10;
        p1_valid = 1; p1_memop = 3'd2; p1_we = 1; p1_addr = 32'h20;
        #3;
        n_cmp += 4;
        if ({p0_ready, p1_ready} !== 2'b00) begin
            n_bad++; $display("FAIL rst_ready got=%b want=00", {p0_ready, p1_ready});
        end
        if (mem_we !== 1'b0) begin
            n_bad++; $display("FAIL rst_mem_we got=%b want=0", mem_we);
        end
        if (mem_addr !== 32'd0 || mem_din !== 32'd0 || mem_memop !== 3'd0) begin
            n_bad++; $display("FAIL rst_mem_cmd got=%h/%h/%0d want=0", mem_addr, mem_din, mem_memop);
        end
        @(posedge clk); #1;
        if ({p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err} !== 4'd0 ||
            p0_rdata !== 32'd0 || p1_rdata !== 32'd0) begin
            n_bad++; $display("FAIL rst_rsp got=%b%b want=00", p0_rsp_valid, p1_rsp_valid);
        end
        @(negedge clk);
        p0_valid = 0; p1_valid = 0;
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_store_load();
        bit g0, g1;
        step(mk(1, 32'h10, 32'hDEADBEEF, 3'd2, 1), idle(), g0, g1);
        n_cmp += 2;
        if (g0 !== 1'b1) begin n_bad++; $display("FAIL sw_ready got=%b want=1", g0); end
        if (p0_rsp_valid !== 1'b1 || p0_rsp_err !== 1'b0 || p0_rdata !== 32'd0) begin
            n_bad++; $display("FAIL sw_rsp got=%b/%b/%h want=1/0/0", p0_rsp_valid, p0_rsp_err, p0_rdata);
        end
        step(mk(1, 32'h10, 32'h0, 3'd2, 0), idle(), g0, g1);
        n_cmp += 2;
        if (g0 !== 1'b1) begin n_bad++; $display("FAIL lw_ready got=%b want=1", g0); end
        if (p0_rdata !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL lw_rdata got=%h want=deadbeef", p0_rdata);
        end
        step(idle(), idle(), g0, g1);
    endtask

    task automatic test_starvation();
        bit g0, g1;
        for (int i = 0; i < 27; i++) begin
            step(mk(1, 32'h40, 32'h0, 3'd2, 0), mk(1, 32'h44 + 32'(4 * (i % 3)), 32'h0, 3'd2, 0), g0, g1);
            n_cmp++;
            if (g1 !== ((i % 9) == 8)) begin
                n_bad++; $display("FAIL starve_grant cycle=%0d got=%b want=%b", i, g1, (i % 9) == 8);
            end
        end
        step(idle(), idle(), g0, g1);
    endtask

    task automatic test_illegal();
        bit    g0, g1;
        breq_t bad [5];
        bad[0] = mk(1, 32'h21, 32'h0, 3'd1, 0);
        bad[1] = mk(1, 32'h22, 32'h0, 3'd2, 0);
        bad[2] = mk(1, 32'h0, 32'h0, 3'd6, 0);
        bad[3] = mk(1, 32'(NBYTES), 32'h0, 3'd2, 0);
        bad[4] = mk(1, 32'h8, 32'h55, 3'd4, 1);
        for (int i = 0; i < 5; i++) begin
            step(idle(), bad[i], g0, g1);
            n_cmp += 2;
            if (g1 !== 1'b1) begin n_bad++; $display("FAIL ill_ready idx=%0d got=%b want=1", i, g1); end
            if (p1_rsp_valid !== 1'b1 || p1_rsp_err !== 1'b1 || p1_rdata !== 32'd0) begin
                n_bad++;
                $display("FAIL ill_rsp idx=%0d got=%b/%b/%h want=1/1/0", i, p1_rsp_valid, p1_rsp_err, p1_rdata);
            end
        end
        step(idle(), idle(), g0, g1);
    endtask

    task automatic test_bytes();
        bit g0, g1;
        step(mk(1, 32'h0, 32'h11223344, 3'd2, 1), idle(), g0, g1);
        step(idle(), mk(1, 32'h3, 32'h000000A5, 3'd0, 1), g0, g1);
        step(mk(1, 32'h3, 32'h0, 3'd0, 0), idle(), g0, g1);
        n_cmp++;
        if (p0_rdata !== 32'hFFFFFFA5) begin n_bad++; $display("FAIL lb_rdata got=%h want=ffffffa5", p0_rdata); end
        step(mk(1, 32'h3, 32'h0, 3'd4, 0), idle(), g0, g1);
        n_cmp++;
        if (p0_rdata !== 32'h000000A5) begin n_bad++; $display("FAIL lbu_rdata got=%h want=000000a5", p0_rdata); end
        step(mk(1, 32'h0, 32'h0, 3'd2, 0), idle(), g0, g1);
        n_cmp++;
        if (p0_rdata !== 32'hA5223344) begin n_bad++; $display("FAIL lw_merge got=%h want=a5223344", p0_rdata); end
        step(idle(), idle(), g0, g1);
    endtask

    task automatic test_wait_clear();
        bit g0, g1;
        for (int i = 0; i < 5; i++) step(mk(1, 32'h40, 0, 3'd2, 0), mk(1, 32'h48, 0, 3'd2, 0), g0, g1);
        step(mk(1, 32'h40, 0, 3'd2, 0), idle(), g0, g1);
        for (int i = 0; i < 9; i++) begin
            step(mk(1, 32'h40, 0, 3'd2, 0), mk(1, 32'h48, 0, 3'd2, 0), g0, g1);
            n_cmp++;
            if (g1 !== (i == 8)) begin
                n_bad++; $display("FAIL wait_restart cycle=%0d got=%b want=%b", i, g1, i == 8);
            end
        end
        step(idle(), idle(), g0, g1);
    endtask

    task automatic test_reset_midresp();
        bit g0, g1;
        step(mk(1, 32'h10, 0, 3'd2, 0), idle(), g0, g1);
        n_cmp++;
        if (p0_rsp_valid !== 1'b1) begin n_bad++; $display("FAIL pre_rst_rsp got=%b want=1", p0_rsp_valid); end
        p0_valid = 1; p1_valid = 1;
        #2 rst_n = 0;
        #1;
        n_cmp += 3;
        if ({p0_rsp_valid, p1_rsp_valid} !== 2'b00 || p0_rdata !== 32'd0) begin
            n_bad++; $display("FAIL async_rst_rsp got=%b%b/%h want=00/0", p0_rsp_valid, p1_rsp_valid, p0_rdata);
        end
        if ({p0_ready, p1_ready, mem_we} !== 3'b000) begin
            n_bad++; $display("FAIL async_rst_ctl got=%b want=000", {p0_ready, p1_ready, mem_we});
        end
        if (mem_addr !== 32'd0) begin n_bad++; $display("FAIL async_rst_addr got=%h want=0", mem_addr); end
        @(posedge clk); #1;
        n_cmp++;
        if ({p0_rsp_valid, p1_rsp_valid} !== 2'b00) begin
            n_bad++; $display("FAIL rst_drop got=%b%b want=00", p0_rsp_valid, p1_rsp_valid);
        end
        @(negedge clk);
        p0_valid = 0; p1_valid = 0;
        rst_n = 1;
        model_reset();
        step(mk(1, 32'h10, 0, 3'd2, 0), idle(), g0, g1);
        n_cmp++;
        if (p0_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL post_rst_lw got=%h want=deadbeef", p0_rdata); end
        step(idle(), idle(), g0, g1);
    endtask

    task automatic test_random();
        bit    g0 = 0, g1 = 0;
        breq_t c0, c1;
        c0 = idle(); c1 = idle();
        for (int i = 0; i < 400; i++) begin
            if (!(c0.v && !g0)) c0 = rnd();
            if (!(c1.v && !g1)) c1 = rnd();
            step(c0, c1, g0, g1);
        end
        step(idle(), idle(), g0, g1);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) dm[i] = 32'd0;
        for (int i = 0; i < NBYTES; i++) mm[i] = 8'd0;
        test_reset();
        test_store_load();
        test_starvation();
        test_illegal();
        test_bytes();
        test_wait_clear();
        test_reset_midresp();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
